boot_loader: RTL and testbench
==============================

Name: boot_loader

Overview:
- Byte-stream program loader that fills the instruction memory of the single-cycle RISC-V core before the core runs.
- Accepts a host byte stream over a valid/ready handshake and packs it little-endian into 32-bit words.
- Writes each word to consecutive word addresses starting at 0.
- Holds the core in reset for the whole load, then releases it after a programmable guard interval.

Parameters:
- DW, 32, instruction word width in bits; only 32 is supported.
- MEM_SIZE_IN_KB, 1, instruction memory size in KB.
- NO_OF_REGS, MEM_SIZE_IN_KB*1024/4, number of words in instruction memory.
- AW, $clog2(NO_OF_REGS), word address width.
- RST_HOLD, 4, cycles core reset stays asserted after the last write; minimum 1.

Ports:
- clk_i  input  1  system clock; all logic on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- start_i  input  1  single-cycle load request; sampled only in IDLE, DONE, ERR.
- len_i  input  AW+1  number of words to load; sampled with start_i.
- byte_valid_i  input  1  host byte valid.
- byte_data_i  input  8  host byte.
- byte_ready_o  output  1  loader can accept a byte.
- mem_we_o  output  1  instruction memory write enable, one cycle per word.
- mem_addr_o  output  AW  word address of the write.
- mem_wdata_o  output  DW  packed word.
- core_rst_o  output  1  active-high reset to the core.
- busy_o  output  1  load in progress (RECV, WRITE or HOLD).
- done_o  output  1  load complete and core released.
- err_o  output  1  illegal length requested.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low, on rst_ni.
- While rst_ni = 0:
  - State is IDLE, and all counters and the word register clear to 0.
  - core_rst_o = 1 immediately, without waiting for a clock edge.
  - byte_ready_o, mem_we_o, busy_o, done_o and err_o = 0.
  - mem_addr_o and mem_wdata_o = 0.
- Outputs are Moore: decoded from registered state and registers only. No output depends combinationally on any input.
- IDLE: core_rst_o = 1, byte_ready_o = 0. On start_i:
  - len_i == 0 or len_i > NO_OF_REGS -> ERR.
  - Otherwise latch len, set addr = 0 and byte_cnt = 0, then go to RECV.
- RECV: byte_ready_o = 1, busy_o = 1.
  - A byte is accepted on any edge where byte_valid_i and byte_ready_o are both 1.
  - The accepted byte goes to bits [8*byte_cnt+7 : 8*byte_cnt]; byte_cnt then increments, mod 4.
  - Accepting the 4th byte of a word goes to WRITE on the next edge.
  - Cycles with byte_valid_i = 0 are stalls: no state change and no timeout.
- WRITE: exactly one cycle.
  - mem_we_o = 1, mem_addr_o = addr, mem_wdata_o = packed word, byte_ready_o = 0.
  - If addr == len-1, go to HOLD and load the hold counter with RST_HOLD-1.
  - Otherwise addr increments and the state returns to RECV.
- HOLD: core_rst_o = 1, busy_o = 1. Counts down, and moves to DONE at count 0. It occupies exactly RST_HOLD cycles.
- DONE: core_rst_o = 0, done_o = 1, byte_ready_o = 0. Bytes presented here are not accepted. On start_i, the length check is repeated:
  - legal -> RECV, with core_rst_o = 1 from that next cycle;
  - illegal -> ERR.
- ERR: err_o = 1, core_rst_o = 1. start_i re-evaluates exactly as in IDLE.
- start_i is ignored in RECV, WRITE and HOLD.
- Throughput: a byte every cycle gives one word per 5 cycles (4 RECV cycles plus 1 WRITE cycle).
- Latency: if the last byte is accepted on edge N:
  - mem_we_o is high during cycle N+1.
  - core_rst_o falls after edge N+1+RST_HOLD.
- Boundaries:
  - len = NO_OF_REGS loads all words; the last address is NO_OF_REGS-1, with no wrap.
  - A reset mid-load discards the partial word; memory contents already written are not cleared.

Test Plan:
- Reset, then start_i with len_i=2; stream bytes 13,00,50,00,93,00,10,00 with valid every cycle -> writes addr0=0x00500013 and addr1=0x00100093. core_rst_o falls 1+4 cycles after the second write, and done_o=1.
- len_i=1 with valid toggling 1,0,1,0 (gaps) -> byte_ready_o stays 1 in RECV; a single write of the correctly packed word happens after the 4th accepted byte.
- start_i with len_i=0, then with len_i=NO_OF_REGS+1 (257) -> err_o=1 and core_rst_o=1 with no writes; a following start_i with len_i=1 recovers into RECV.
- len_i=256 -> 256 writes at addresses 0..255; the last write is at 255 with no wrap; done_o is set.
- Deassert rst_ni asynchronously after 2 bytes of a word -> core_rst_o=1 and the state returns to IDLE with no clock edge; no mem_we_o pulse follows. A fresh load then starts at addr 0.
- In DONE, pulse start_i with len_i=1 -> core_rst_o=1 on the next cycle, done_o=0, and a new load proceeds normally.

Source files
------------

// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - byte-stream loader for instruction memory with core reset sequencing
//
// Accepts host bytes over a valid/ready handshake and packs them little-endian
// into 32-bit words. Each word is written to consecutive word addresses from 0.
// The core is held in reset throughout the load and is released RST_HOLD cycles
// after the last write.
//
// Ports:
//   clk_i, rst_ni               clock, asynchronous active-low reset
//   start_i, len_i              load request and word count (sampled in IDLE/DONE/ERR)
//   byte_valid_i, byte_data_i   host byte stream
//   byte_ready_o                loader accepts a byte this cycle
//   mem_we_o, mem_addr_o,
//   mem_wdata_o                 instruction memory write port, one cycle per word
//   core_rst_o                  active-high reset to the core
//   busy_o, done_o, err_o       status
module boot_loader #(
  parameter int DW             = 32,
  parameter int MEM_SIZE_IN_KB = 1,
  parameter int NO_OF_REGS     = MEM_SIZE_IN_KB * 1024 / 4,
  parameter int AW             = $clog2(NO_OF_REGS),
  parameter int RST_HOLD       = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [AW:0]   len_i,
  input  logic          byte_valid_i,
  input  logic [7:0]    byte_data_i,
  output logic          byte_ready_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic          core_rst_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RECV  = 3'd1;
  localparam logic [2:0] WRITE = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  localparam logic [2:0] ERR   = 3'd5;

  localparam int          HW      = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [AW:0] MAX_LEN = (AW+1)'(NO_OF_REGS);

  logic [2:0]    state_q;
  logic [AW:0]   len_q;
  logic [AW-1:0] addr_q;
  logic [1:0]    byte_cnt_q;
  logic [DW-1:0] word_q;
  logic [HW-1:0] hold_q;
  logic          len_ok;
  logic          last_word;

  assign len_ok    = (len_i != '0) && (len_i <= MAX_LEN);
  assign last_word = ({1'b0, addr_q} == (len_q - (AW+1)'(1)));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      len_q      <= '0;
      addr_q     <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      hold_q     <= '0;
    end else begin
      case (state_q)
        IDLE, DONE, ERR: begin
          if (start_i) begin
            if (len_ok) begin
              state_q    <= RECV;
              len_q      <= len_i;
              addr_q     <= '0;
              byte_cnt_q <= '0;
            end else begin
              state_q <= ERR;
            end
          end
        end
        RECV: begin
          // byte_ready_o is high for the whole of RECV, so valid alone completes the handshake
          if (byte_valid_i) begin
            word_q[{byte_cnt_q, 3'b000} +: 8] <= byte_data_i;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              state_q <= WRITE;
            end
          end
        end
        WRITE: begin
          if (last_word) begin
            state_q <= HOLD;
            hold_q  <= HW'(RST_HOLD - 1);
          end else begin
            addr_q  <= addr_q + AW'(1);
            state_q <= RECV;
          end
        end
        HOLD: begin
          if (hold_q == '0) begin
            state_q <= DONE;
          end else begin
            hold_q <= hold_q - HW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Moore outputs; reset forces state to IDLE asynchronously, which raises core_rst_o at once
  assign byte_ready_o = (state_q == RECV);
  assign mem_we_o     = (state_q == WRITE);
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = word_q;
  assign core_rst_o   = (state_q != DONE);
  assign busy_o       = (state_q == RECV) || (state_q == WRITE) || (state_q == HOLD);
  assign done_o       = (state_q == DONE);
  assign err_o        = (state_q == ERR);

endmodule

// File: tb/tb_boot_loader.sv
// tb/tb_boot_loader.sv - self-checking bench for boot_loader
`timescale 1ns/1ps
module tb_boot_loader;

  localparam int NREGS    = 256;
  localparam int AW       = 8;
  localparam int RST_HOLD = 4;

  logic          clk_i;
  logic          rst_ni;
  logic          start_i;
  logic [AW:0]   len_i;
  logic          byte_valid_i;
  logic [7:0]    byte_data_i;
  logic          byte_ready_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic          core_rst_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];
  logic [7:0]    bq[$];
  time           last_we_t = 0;

  boot_loader #(.RST_HOLD(RST_HOLD)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .len_i        (len_i),
    .byte_valid_i (byte_valid_i),
    .byte_data_i  (byte_data_i),
    .byte_ready_o (byte_ready_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .core_rst_o   (core_rst_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (mem_we_o === 1'b1) begin
      wa_q.push_back(mem_addr_o);
      wd_q.push_back(mem_wdata_o);
      last_we_t = $time;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input int len);
    @(negedge clk_i);
    start_i = 1'b1;
    len_i   = (AW+1)'(len);
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic gen_bytes(input int n);
    bq.delete();
    for (int k = 0; k < n; k++) bq.push_back(8'($urandom_range(0, 255)));
  endtask

  // mode 0: valid every cycle, 1: valid on alternate cycles, 2: random gaps
  task automatic send_bytes(input int mode);
    int i = 0;
    int g = 0;
    int ph = 0;
    bit gap;
    while (i < bq.size() && g < 20000) begin
      @(negedge clk_i);
      g++;
      gap = (mode == 1) ? (ph % 2 == 1) : ((mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0);
      if (gap) begin
        byte_valid_i = 1'b0;
        if (mode == 1) chk("gap_ready", byte_ready_o, 1'b1);
      end else begin
        byte_valid_i = 1'b1;
        byte_data_i  = bq[i];
        if (byte_ready_o) i++;
      end
      ph++;
    end
    chk("send_complete", i, bq.size());
    @(negedge clk_i);
    byte_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int g = 0;
    while (done_o !== 1'b1 && g < 200) begin
      @(negedge clk_i);
      g++;
    end
    chk(tag, done_o, 1'b1);
  endtask

  // Reference: word w of the load is bytes 4w..4w+3, least significant byte first
  task automatic check_writes(input string tag, input int len);
    chk({tag, "_count"}, wa_q.size(), len);
    for (int w = 0; w < len && w < wa_q.size(); w++) begin
      int unsigned e = 0;
      for (int k = 0; k < 4; k++) e += int'(bq[4*w+k]) << (8*k);
      chk({tag, "_addr"}, wa_q[w], w);
      chk({tag, "_data"}, wd_q[w], e);
    end
  endtask

  initial begin
    rst_ni = 1'b1; start_i = 1'b0; len_i = '0; byte_valid_i = 1'b0; byte_data_i = '0;

    // asynchronous reset with no clock edge yet
    #1 rst_ni = 1'b0;
    #1;
    chk("rst_core_rst", core_rst_o, 1'b1);
    chk("rst_ready", byte_ready_o, 1'b0);
    chk("rst_we", mem_we_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("idle_core_rst", core_rst_o, 1'b1);
    chk("idle_ready", byte_ready_o, 1'b0);

    // two-word load, valid every cycle
    wa_q.delete(); wd_q.delete();
    bq = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    do_start(2);
    chk("t1_busy", busy_o, 1'b1);
    chk("t1_ready", byte_ready_o, 1'b1);
    start_i = 1'b1; len_i = '0;
    @(negedge clk_i);
    start_i = 1'b0;
    chk("t1_start_ignored", err_o, 1'b0);
    chk("t1_still_busy", busy_o, 1'b1);
    send_bytes(0);
    chk("t1_hold_core_rst", core_rst_o, 1'b1);
    wait_done("t1_done");
    check_writes("t1", 2);
    if (wd_q.size() >= 2) begin
      chk("t1_word0", wd_q[0], 32'h00500013);
      chk("t1_word1", wd_q[1], 32'h00100093);
    end
    chk("t1_release_latency", ($time - last_we_t) / 10, RST_HOLD + 1);
    chk("t1_core_released", core_rst_o, 1'b0);
    chk("t1_not_busy", busy_o, 1'b0);

    // restart from DONE, one word with alternating valid
    wa_q.delete(); wd_q.delete();
    gen_bytes(4);
    do_start(1);
    chk("t6_core_rst", core_rst_o, 1'b1);
    chk("t6_done_clr", done_o, 1'b0);
    chk("t6_ready", byte_ready_o, 1'b1);
    send_bytes(1);
    wait_done("t2_done");
    check_writes("t2", 1);

    // illegal lengths, then recovery
    wa_q.delete(); wd_q.delete();
    do_start(0);
    chk("t3_err_len0", err_o, 1'b1);
    chk("t3_core_rst0", core_rst_o, 1'b1);
    chk("t3_busy0", busy_o, 1'b0);
    do_start(NREGS + 1);
    chk("t3_err_len257", err_o, 1'b1);
    chk("t3_core_rst257", core_rst_o, 1'b1);
    chk("t3_no_writes", wa_q.size(), 0);
    gen_bytes(4);
    do_start(1);
    chk("t3_recover_busy", busy_o, 1'b1);
    chk("t3_recover_err", err_o, 1'b0);
    chk("t3_recover_ready", byte_ready_o, 1'b1);
    send_bytes(2);
    wait_done("t3_done");
    check_writes("t3", 1);

    // full memory load
    wa_q.delete(); wd_q.delete();
    gen_bytes(4 * NREGS);
    do_start(NREGS);
    send_bytes(2);
    wait_done("t4_done");
    check_writes("t4", NREGS);
    if (wa_q.size() > 0) chk("t4_last_addr", wa_q[wa_q.size()-1], NREGS - 1);

    // asynchronous reset after two bytes of a word
    wa_q.delete(); wd_q.delete();
    do_start(3);
    gen_bytes(2);
    send_bytes(0);
    #2 rst_ni = 1'b0;
    #1;
    chk("t5_core_rst", core_rst_o, 1'b1);
    chk("t5_busy", busy_o, 1'b0);
    chk("t5_ready", byte_ready_o, 1'b0);
    chk("t5_wdata", mem_wdata_o, 0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("t5_no_write", wa_q.size(), 0);
    gen_bytes(8);
    do_start(2);
    send_bytes(2);
    wait_done("t5_done");
    check_writes("t5", 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
